// File: rtl/endat_poll_ctrl.sv
// -----------------------------------------------------------------------------
// endat_poll_ctrl
//
// Poll scheduler and supervisor for an EnDat 2.2 position receiver. It starts
// receiver transactions periodically or on software request and holds the
// receiver in reset between transactions. It supervises completion with a
// timeout, gates results on an external CRC verdict, retries failed reads and
// latches the last good position.
//
// Ports
//   enc_clk      clock
//   rst          synchronous active-high reset
//   en           enables periodic ticks; 0 holds the period counter at 0
//   sw_req       one-cycle software poll request
//   clr_fault    leaves FAULT, clears retry count and pending request
//   rx_run       receiver rst_n: 1 releases the receiver, 0 holds it in reset
//   rx_valid     receiver enc_valid (level)
//   rx_pos       receiver enc_pos
//   rx_crc_ok    external CRC verdict, valid while rx_valid=1
//   pos_out      last good position
//   pos_valid    one-cycle pulse when pos_out updates
//   busy         1 whenever the controller is not IDLE
//   err_timeout  one-cycle pulse on a receiver timeout
//   err_crc      one-cycle pulse on a CRC failure
//   err_cnt      saturating total error count
//   fault        1 while in FAULT
// -----------------------------------------------------------------------------
module endat_poll_ctrl #(
    parameter int PERIOD    = 1000,
    parameter int TIMEOUT   = 200,
    parameter int RECOVERY  = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic        enc_clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sw_req,
    input  logic        clr_fault,
    output logic        rx_run,
    input  logic        rx_valid,
    input  logic [25:0] rx_pos,
    input  logic        rx_crc_ok,
    output logic [25:0] pos_out,
    output logic        pos_valid,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_crc,
    output logic [7:0]  err_cnt,
    output logic        fault
);

    localparam int PER_W = (PERIOD   > 1) ? $clog2(PERIOD)   : 1;
    localparam int TO_W  = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
    localparam int REC_W = (RECOVERY > 1) ? $clog2(RECOVERY) : 1;

    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [REC_W-1:0] REC_LAST  = REC_W'(RECOVERY - 1);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        CHECK   = 3'd3,
        RECOVER = 3'd4,
        FAULT   = 3'd5
    } state_t;

    state_t           state_q,       state_d;
    logic [PER_W-1:0] per_cnt_q,     per_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,      to_cnt_d;
    logic [REC_W-1:0] rec_cnt_q,     rec_cnt_d;
    logic [2:0]       retry_q,       retry_d;
    logic             retry_go_q,    retry_go_d;
    logic             pend_q,        pend_d;
    logic             rx_valid_p_q,  rx_valid_p_d;
    logic             rx_run_q,      rx_run_d;
    logic [25:0]      pos_out_q,     pos_out_d;
    logic             pos_valid_q,   pos_valid_d;
    logic             busy_q,        busy_d;
    logic             err_to_q,      err_to_d;
    logic             err_crc_q,     err_crc_d;
    logic [7:0]       err_cnt_q,     err_cnt_d;
    logic             fault_q,       fault_d;

    logic tick;
    logic rise;
    logic fail;
    logic take;

    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        to_cnt_d     = '0;
        rec_cnt_d    = '0;
        retry_d      = retry_q;
        retry_go_d   = retry_go_q;
        pend_d       = pend_q;
        rx_valid_p_d = rx_valid;
        pos_out_d    = pos_out_q;
        pos_valid_d  = 1'b0;
        err_to_d     = 1'b0;
        err_crc_d    = 1'b0;
        err_cnt_d    = err_cnt_q;
        fail         = 1'b0;
        take         = 1'b0;

        // Free-running period counter; en=0 parks it at zero so enabling
        // always gives a full period before the first tick.
        tick = (per_cnt_q == PER_LAST);
        if (!en || tick) begin
            per_cnt_d = '0;
        end else begin
            per_cnt_d = per_cnt_q + 1'b1;
        end

        rise = rx_valid & ~rx_valid_p_q;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    take    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                to_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // A completion in the last allowed cycle still wins.
                if (rise) begin
                    state_d = CHECK;
                end else if (to_cnt_q == TO_LAST) begin
                    err_to_d = 1'b1;
                    fail     = 1'b1;
                end
            end
            CHECK: begin
                if (rx_crc_ok) begin
                    pos_out_d   = rx_pos;
                    pos_valid_d = 1'b1;
                    retry_d     = '0;
                    state_d     = RECOVER;
                end else begin
                    err_crc_d = 1'b1;
                    fail      = 1'b1;
                end
            end
            RECOVER: begin
                if (rec_cnt_q == REC_LAST) begin
                    if (retry_go_q) begin
                        retry_go_d = 1'b0;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rec_cnt_d = rec_cnt_q + 1'b1;
                end
            end
            FAULT: begin
                if (clr_fault) begin
                    retry_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Error resolution happens in the same cycle as the error itself,
        // so there is no visible FAIL state.
        if (fail) begin
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (retry_q == RETRY_MAX) begin
                state_d = FAULT;
            end else begin
                retry_d    = retry_q + 1'b1;
                retry_go_d = 1'b1;
                state_d    = RECOVER;
            end
        end

        // One-deep request latch. A request in the same cycle as the
        // IDLE->START hand-off is kept rather than lost.
        if (take) begin
            pend_d = 1'b0;
        end
        if (state_q == FAULT) begin
            if (clr_fault) begin
                pend_d = 1'b0;
            end
        end else if (tick || sw_req) begin
            pend_d = 1'b1;
        end

        // Outputs are registered decodes of the next state.
        rx_run_d = (state_d == START) || (state_d == WAIT) || (state_d == CHECK);
        busy_d   = (state_d != IDLE);
        fault_d  = (state_d == FAULT);
    end

    always_ff @(posedge enc_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            per_cnt_q    <= '0;
            to_cnt_q     <= '0;
            rec_cnt_q    <= '0;
            retry_q      <= '0;
            retry_go_q   <= 1'b0;
            pend_q       <= 1'b0;
            rx_valid_p_q <= 1'b0;
            rx_run_q     <= 1'b0;
            pos_out_q    <= '0;
            pos_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_to_q     <= 1'b0;
            err_crc_q    <= 1'b0;
            err_cnt_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            to_cnt_q     <= to_cnt_d;
            rec_cnt_q    <= rec_cnt_d;
            retry_q      <= retry_d;
            retry_go_q   <= retry_go_d;
            pend_q       <= pend_d;
            rx_valid_p_q <= rx_valid_p_d;
            rx_run_q     <= rx_run_d;
            pos_out_q    <= pos_out_d;
            pos_valid_q  <= pos_valid_d;
            busy_q       <= busy_d;
            err_to_q     <= err_to_d;
            err_crc_q    <= err_crc_d;
            err_cnt_q    <= err_cnt_d;
            fault_q      <= fault_d;
        end
    end

    assign rx_run      = rx_run_q;
    assign pos_out     = pos_out_q;
    assign pos_valid   = pos_valid_q;
    assign busy        = busy_q;
    assign err_timeout = err_to_q;
    assign err_crc     = err_crc_q;
    assign err_cnt     = err_cnt_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_endat_poll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_endat_poll_ctrl
//
// Scoreboard bench for endat_poll_ctrl. Directed stimulus pushes the expected
// output events (pos_valid / err_timeout / err_crc with pos_out and err_cnt)
// into a queue; an independent monitor pops and compares on every event.
// A small behavioural receiver answers rx_run with rx_valid after a delay.
// -----------------------------------------------------------------------------
module tb_endat_poll_ctrl;

    localparam int PERIOD    = 50;
    localparam int TIMEOUT   = 20;
    localparam int RECOVERY  = 4;
    localparam int MAX_RETRY = 2;

    logic        enc_clk   = 1'b0;
    logic        rst       = 1'b1;
    logic        en        = 1'b0;
    logic        sw_req    = 1'b0;
    logic        clr_fault = 1'b0;
    logic        rx_run;
    logic        rx_valid;
    logic [25:0] rx_pos;
    logic        rx_crc_ok;
    logic [25:0] pos_out;
    logic        pos_valid;
    logic        busy;
    logic        err_timeout;
    logic        err_crc;
    logic [7:0]  err_cnt;
    logic        fault;

    endat_poll_ctrl #(
        .PERIOD    (PERIOD),
        .TIMEOUT   (TIMEOUT),
        .RECOVERY  (RECOVERY),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .enc_clk     (enc_clk),
        .rst         (rst),
        .en          (en),
        .sw_req      (sw_req),
        .clr_fault   (clr_fault),
        .rx_run      (rx_run),
        .rx_valid    (rx_valid),
        .rx_pos      (rx_pos),
        .rx_crc_ok   (rx_crc_ok),
        .pos_out     (pos_out),
        .pos_valid   (pos_valid),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_crc     (err_crc),
        .err_cnt     (err_cnt),
        .fault       (fault)
    );

    always #5 enc_clk = ~enc_clk;

    int cyc = 0;
    always @(posedge enc_clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  kind;   // {pos_valid, err_timeout, err_crc}
        logic [25:0] pos;
        logic [7:0]  errc;
    } exp_t;

    localparam logic [2:0] K_POS = 3'b100;
    localparam logic [2:0] K_TO  = 3'b010;
    localparam logic [2:0] K_CRC = 3'b001;

    exp_t exp_q[$];
    int   ev_cyc[$];
    int   ev_cnt = 0;
    int   tests  = 0;
    int   fails  = 0;

    // receiver model controls
    logic        resp_en    = 1'b1;
    int          resp_delay = 5;
    logic [25:0] resp_pos   = 26'h0012345;
    logic        crc_q[$];
    int          txn_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_exp(input logic [2:0] kind, input logic [25:0] pos, input logic [7:0] errc);
        exp_t e;
        e.kind = kind;
        e.pos  = pos;
        e.errc = errc;
        exp_q.push_back(e);
    endtask

    task automatic pulse_sw();
        sw_req = 1'b1;
        @(negedge enc_clk);
        sw_req = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_fault = 1'b1;
        @(negedge enc_clk);
        clr_fault = 1'b0;
    endtask

    task automatic wait_events(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (ev_cnt < target && n < budget) begin
            @(posedge enc_clk);
            n++;
        end
        @(negedge enc_clk);
        tests++;
        if (ev_cnt < target) begin
            fails++;
            $display("FAIL %s: got %0d events, expected %0d within %0d cycles", name, ev_cnt, target, budget);
        end
    endtask

    // Behavioural receiver: counts cycles of rx_run=1, raises rx_valid after
    // resp_delay cycles and holds it until rx_run drops.
    initial begin
        int  rcv_cnt;
        logic run_prev;
        rx_valid  = 1'b0;
        rx_pos    = '0;
        rx_crc_ok = 1'b0;
        rcv_cnt   = 0;
        run_prev  = 1'b0;
        forever begin
            @(negedge enc_clk);
            if (rx_run !== 1'b1) begin
                rx_valid = 1'b0;
                rcv_cnt  = 0;
            end else begin
                if (!run_prev) txn_cnt++;
                rcv_cnt++;
                if (resp_en && rcv_cnt == resp_delay) begin
                    rx_valid = 1'b1;
                    rx_pos   = resp_pos;
                    if (crc_q.size() > 0) rx_crc_ok = crc_q.pop_front();
                    else                  rx_crc_ok = 1'b1;
                end
            end
            run_prev = (rx_run === 1'b1);
        end
    end

    // Monitor: every output event pops one expectation.
    always @(negedge enc_clk) begin
        exp_t e;
        if (!rst && (pos_valid || err_timeout || err_crc)) begin
            ev_cnt++;
            ev_cyc.push_back(cyc);
            $display("[TB] event cyc=%0d kind=%b pos_out=0x%07h err_cnt=%0d",
                     cyc, {pos_valid, err_timeout, err_crc}, pos_out, err_cnt);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected event: got kind %b, expected none", {pos_valid, err_timeout, err_crc});
            end else begin
                e = exp_q.pop_front();
                check("event kind", {29'b0, pos_valid, err_timeout, err_crc}, {29'b0, e.kind});
                check("pos_out at event", {6'b0, pos_out}, {6'b0, e.pos});
                check("err_cnt at event", {24'b0, err_cnt}, {24'b0, e.errc});
                check("rx_run at event", {31'b0, rx_run}, 32'd0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int tgt;
        int sw_c;
        int tb0;
        int ev0;
        logic [7:0] exp_err;

        // ---------------- reset state ----------------
        repeat (3) @(negedge enc_clk);
        check("reset rx_run",      {31'b0, rx_run},      32'd0);
        check("reset busy",        {31'b0, busy},        32'd0);
        check("reset pos_out",     {6'b0, pos_out},      32'd0);
        check("reset pos_valid",   {31'b0, pos_valid},   32'd0);
        check("reset err_timeout", {31'b0, err_timeout}, 32'd0);
        check("reset err_crc",     {31'b0, err_crc},     32'd0);
        check("reset err_cnt",     {24'b0, err_cnt},     32'd0);
        check("reset fault",       {31'b0, fault},       32'd0);
        rst = 1'b0;
        repeat (5) @(negedge enc_clk);

        // ---------------- periodic good reads ----------------
        b = ev_cyc.size();
        tgt = ev_cnt + 3;
        resp_en = 1'b1; resp_delay = 5; resp_pos = 26'h0012345;
        repeat (3) push_exp(K_POS, 26'h0012345, 8'd0);
        en = 1'b1;
        wait_events(tgt, 250, "periodic reads");
        en = 1'b0;
        check("period interval 1", ev_cyc[b+1] - ev_cyc[b], PERIOD);
        check("period interval 2", ev_cyc[b+2] - ev_cyc[b+1], PERIOD);
        repeat (20) @(negedge enc_clk);
        check("idle after periodic", {31'b0, busy}, 32'd0);

        // ---------------- timeout with retries -> FAULT ----------------
        resp_en = 1'b0;
        b = ev_cyc.size();
        tgt = ev_cnt + 3;
        push_exp(K_TO, 26'h0012345, 8'd1);
        push_exp(K_TO, 26'h0012345, 8'd2);
        push_exp(K_TO, 26'h0012345, 8'd3);
        sw_c = cyc;
        pulse_sw();
        wait_events(tgt, 300, "timeout retries");
        check("first timeout latency", ev_cyc[b] - sw_c, 23);
        check("retry interval 1", ev_cyc[b+1] - ev_cyc[b], RECOVERY + TIMEOUT + 1);
        check("retry interval 2", ev_cyc[b+2] - ev_cyc[b+1], RECOVERY + TIMEOUT + 1);
        check("fault after retries", {31'b0, fault}, 32'd1);
        check("rx_run in fault", {31'b0, rx_run}, 32'd0);
        check("busy in fault", {31'b0, busy}, 32'd1);

        // requests in FAULT are dropped
        ev0 = ev_cnt;
        pulse_sw();
        repeat (30) @(negedge enc_clk);
        check("no event in fault", ev_cnt, ev0);
        check("fault held", {31'b0, fault}, 32'd1);
        check("rx_run held low", {31'b0, rx_run}, 32'd0);
        pulse_clr();
        check("fault cleared", {31'b0, fault}, 32'd0);
        check("idle after clear", {31'b0, busy}, 32'd0);
        repeat (10) @(negedge enc_clk);
        check("dropped request stays idle", {31'b0, busy}, 32'd0);

        // ---------------- CRC failure then good retry ----------------
        resp_en = 1'b1; resp_delay = 5; resp_pos = 26'h2ABCDEF;
        crc_q.push_back(1'b0);
        tgt = ev_cnt + 2;
        push_exp(K_CRC, 26'h0012345, 8'd4);
        push_exp(K_POS, 26'h2ABCDEF, 8'd4);
        pulse_sw();
        wait_events(tgt, 200, "crc retry");
        check("no fault after crc retry", {31'b0, fault}, 32'd0);
        check("pos_out after crc retry", {6'b0, pos_out}, 32'h2ABCDEF);
        repeat (20) @(negedge enc_clk);

        // ---------------- request coalescing ----------------
        resp_delay = 15; resp_pos = 26'h1555AAA;
        tb0 = txn_cnt;
        tgt = ev_cnt + 2;
        push_exp(K_POS, 26'h1555AAA, 8'd4);
        push_exp(K_POS, 26'h1555AAA, 8'd4);
        en = 1'b1;                       // tick lands ~49 cycles from here
        repeat (40) @(negedge enc_clk);
        pulse_sw();                      // starts the transaction
        repeat (3) @(negedge enc_clk);
        pulse_sw();                      // three more requests during WAIT
        repeat (1) @(negedge enc_clk);
        pulse_sw();
        repeat (5) @(negedge enc_clk);
        pulse_sw();
        repeat (2) @(negedge enc_clk);
        en = 1'b0;
        wait_events(tgt, 300, "coalesced reads");
        repeat (150) @(negedge enc_clk);
        check("coalesced transaction count", txn_cnt - tb0, 2);
        check("idle after coalescing", {31'b0, busy}, 32'd0);

        // ---------------- repeated FAULT rounds, err_cnt saturation ----------------
        resp_en = 1'b0;
        exp_err = 8'd4;
        for (int r = 0; r < 100; r++) begin
            tgt = ev_cnt + 3;
            for (int k = 0; k < 3; k++) begin
                if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                push_exp(K_TO, 26'h1555AAA, exp_err);
            end
            pulse_sw();
            wait_events(tgt, 300, "fault round");
            check("fault each round", {31'b0, fault}, 32'd1);
            pulse_clr();
        end
        check("err_cnt saturated", {24'b0, err_cnt}, 32'd255);

        // normal poll after clearing the fault
        resp_en = 1'b1; resp_delay = 5; resp_pos = 26'h0ABCDEF;
        tgt = ev_cnt + 1;
        push_exp(K_POS, 26'h0ABCDEF, 8'd255);
        pulse_sw();
        wait_events(tgt, 200, "poll after clear");
        check("no fault after poll", {31'b0, fault}, 32'd0);
        repeat (20) @(negedge enc_clk);

        // ---------------- reset mid-WAIT ----------------
        resp_en = 1'b0;
        ev0 = ev_cnt;
        pulse_sw();
        repeat (8) @(negedge enc_clk);
        check("rx_run before reset", {31'b0, rx_run}, 32'd1);
        rst = 1'b1;
        @(negedge enc_clk);
        rst = 1'b0;
        check("mid reset rx_run",  {31'b0, rx_run},  32'd0);
        check("mid reset busy",    {31'b0, busy},    32'd0);
        check("mid reset err_cnt", {24'b0, err_cnt}, 32'd0);
        check("mid reset pos_out", {6'b0, pos_out},  32'd0);
        check("mid reset fault",   {31'b0, fault},   32'd0);
        repeat (60) @(negedge enc_clk);
        check("no events after reset", ev_cnt, ev0);
        check("idle after reset", {31'b0, busy}, 32'd0);

        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
